// File: rtl/uart_rsp_collector.sv
// UART response collector: deframes TX_OUT bytes and assembles 1/2-byte responses.
// Optional expectation timeout compiled in with `define RSP_TIMEOUT_EN.
module uart_rsp_collector #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SER_IN,
    input  logic [5:0]  PRESCALE,
    input  logic        PAR_EN,
    input  logic        PAR_TYP,
    input  logic        EXP_VLD,
    input  logic        EXP_TWO,
    output logic        BUSY,
    output logic [15:0] RSP_DATA,
    output logic        RSP_VLD,
    output logic        PAR_ERR,
    output logic        STP_ERR,
    output logic        UNEXP,
    output logic        TIMEOUT
);

    typedef enum logic [2:0] {
        D_IDLE, D_START, D_DATA, D_PAR, D_STOP
    } dstate_t;

    typedef enum logic [1:0] {
        A_WAIT, A_BYTE0, A_BYTE1
    } astate_t;

    dstate_t     dstate;
    astate_t     astate;
    logic        sync1;
    logic        sync2;
    logic [5:0]  cnt;
    logic [5:0]  ps;
    logic [5:0]  half;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  byte0;
    logic        two;
    logic        par_bad;
    logic        smp;
    logic        wrap;
    logic        frame_end;
    logic        byte_good;
    logic        byte_err;
    logic        to_hit;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= SER_IN;
            sync2 <= sync1;
        end
    end

    // Unsupported ratios fall back to 8x oversampling
    always_comb begin
        ps = 6'd8;
        if (PRESCALE == 6'd16 || PRESCALE == 6'd32)
            ps = PRESCALE;
        half      = (ps >> 1) - 6'd1;
        smp       = (cnt == half);
        wrap      = (cnt == ps - 6'd1);
        frame_end = (dstate == D_STOP) && smp;
        byte_good = frame_end && sync2 && !par_bad;
        byte_err  = frame_end && (!sync2 || par_bad);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            dstate  <= D_IDLE;
            cnt     <= 6'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            par_bad <= 1'b0;
        end else begin
            cnt <= (dstate == D_IDLE || wrap) ? 6'd0 : cnt + 6'd1;
            unique case (dstate)
                D_IDLE: begin
                    if (!sync2)
                        dstate <= D_START;
                end
                D_START: begin
                    if (smp && sync2) begin
                        dstate <= D_IDLE;
                    end else if (wrap) begin
                        dstate  <= D_DATA;
                        bit_idx <= 3'd0;
                        par_bad <= 1'b0;
                    end
                end
                D_DATA: begin
                    if (smp)
                        shreg <= {sync2, shreg[7:1]};
                    if (wrap) begin
                        if (bit_idx == 3'd7)
                            dstate <= PAR_EN ? D_PAR : D_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                D_PAR: begin
                    if (smp)
                        par_bad <= sync2 != (^shreg ^ PAR_TYP);
                    if (wrap)
                        dstate <= D_STOP;
                end
                D_STOP: begin
                    if (smp)
                        dstate <= D_IDLE;
                end
                default: dstate <= D_IDLE;
            endcase
        end
    end

`ifdef RSP_TIMEOUT_EN
    logic [12:0] tcnt;

    always_ff @(posedge CLK) begin
        if (!RST)
            tcnt <= 13'd0;
        else if ((astate == A_WAIT && EXP_VLD) || byte_good || to_hit)
            tcnt <= 13'd0;
        else if (dstate == D_IDLE)
            tcnt <= tcnt + 13'd1;
    end

    assign to_hit = BUSY && !frame_end && (tcnt == 13'(TIMEOUT_CYC - 1));
`else
    // No counter: an expectation waits indefinitely
    assign to_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            astate   <= A_WAIT;
            BUSY     <= 1'b0;
            RSP_DATA <= 16'h0000;
            RSP_VLD  <= 1'b0;
            PAR_ERR  <= 1'b0;
            STP_ERR  <= 1'b0;
            UNEXP    <= 1'b0;
            TIMEOUT  <= 1'b0;
            two      <= 1'b0;
            byte0    <= 8'h00;
        end else begin
            RSP_VLD <= 1'b0;
            UNEXP   <= 1'b0;
            TIMEOUT <= 1'b0;
            PAR_ERR <= frame_end && par_bad;
            STP_ERR <= frame_end && !sync2;
            unique case (astate)
                A_WAIT: begin
                    if (byte_good)
                        UNEXP <= 1'b1;
                    if (EXP_VLD) begin
                        astate <= A_BYTE0;
                        two    <= EXP_TWO;
                        BUSY   <= 1'b1;
                    end
                end
                A_BYTE0: begin
                    if (byte_err) begin
                        astate <= A_WAIT;
                        BUSY   <= 1'b0;
                    end else if (byte_good) begin
                        if (two) begin
                            byte0  <= shreg;
                            astate <= A_BYTE1;
                        end else begin
                            RSP_DATA <= {8'h00, shreg};
                            RSP_VLD  <= 1'b1;
                            astate   <= A_WAIT;
                            BUSY     <= 1'b0;
                        end
                    end
                end
                A_BYTE1: begin
                    if (byte_err) begin
                        astate <= A_WAIT;
                        BUSY   <= 1'b0;
                    end else if (byte_good) begin
                        RSP_DATA <= {shreg, byte0};
                        RSP_VLD  <= 1'b1;
                        astate   <= A_WAIT;
                        BUSY     <= 1'b0;
                    end
                end
                default: begin
                    astate <= A_WAIT;
                    BUSY   <= 1'b0;
                end
            endcase
            if (to_hit) begin
                TIMEOUT <= 1'b1;
                astate  <= A_WAIT;
                BUSY    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rsp_collector.sv
// Self-checking bench for uart_rsp_collector: directed plan items plus
// randomized frames checked against a transaction-level response model.
module tb_uart_rsp_collector;

    localparam int TO_CYC = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        SER_IN;
    logic [5:0]  PRESCALE;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        EXP_VLD;
    logic        EXP_TWO;
    logic        BUSY;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        PAR_ERR;
    logic        STP_ERR;
    logic        UNEXP;
    logic        TIMEOUT;

    always #5 CLK = ~CLK;

    uart_rsp_collector #(.TIMEOUT_CYC(TO_CYC)) dut (
        .CLK(CLK), .RST(RST), .SER_IN(SER_IN), .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .EXP_VLD(EXP_VLD),
        .EXP_TWO(EXP_TWO), .BUSY(BUSY), .RSP_DATA(RSP_DATA),
        .RSP_VLD(RSP_VLD), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
        .UNEXP(UNEXP), .TIMEOUT(TIMEOUT)
    );

    int checks = 0;
    int failures = 0;

    // Observed pulse activity
    int n_vld = 0, n_par = 0, n_stp = 0, n_unx = 0, n_to = 0;
    int busy_viol = 0;
    int cyc = 0, to_cyc = 0, frame_cyc = 0;
    logic [15:0] last_rsp = 16'h0;

    // Model expectations
    int e_vld = 0, e_par = 0, e_stp = 0, e_unx = 0, e_to = 0;
    logic [15:0] e_rsp = 16'h0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RSP_VLD) begin
            n_vld++;
            last_rsp = RSP_DATA;
        end
        if (PAR_ERR) n_par++;
        if (STP_ERR) n_stp++;
        if (UNEXP) n_unx++;
        if (TIMEOUT) begin
            n_to++;
            to_cyc = cyc;
        end
        if ((RSP_VLD || PAR_ERR || STP_ERR || TIMEOUT) && BUSY)
            busy_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".vld"}, n_vld, e_vld);
        chk({tag, ".par"}, n_par, e_par);
        chk({tag, ".stp"}, n_stp, e_stp);
        chk({tag, ".unx"}, n_unx, e_unx);
        chk({tag, ".to"}, n_to, e_to);
        chk({tag, ".data"}, RSP_DATA, e_rsp);
        chk({tag, ".busy"}, BUSY, 0);
        chk({tag, ".bviol"}, busy_viol, 0);
    endtask

    function automatic int bitlen(input logic [5:0] p);
        return (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    task automatic post(input bit two);
        EXP_VLD = 1'b1;
        EXP_TWO = two;
        @(negedge CLK);
        EXP_VLD = 1'b0;
    endtask

    // One frame on the line; optionally pulses EXP_VLD at the start of bit post_at
    task automatic send_frame(input logic [7:0] b, input bit pe, input bit pbit,
                              input bit stop, input int bl, input int post_at,
                              input bit two);
        logic [10:0] bits;
        int nb;
        bits = {stop, pbit, b, 1'b0};
        if (!pe) bits = {1'b1, stop, b, 1'b0};
        nb = pe ? 11 : 10;
        for (int i = 0; i < nb; i++) begin
            SER_IN = bits[i];
            if (i == 0) frame_cyc = cyc;
            if (i == post_at) begin
                post(two);
                repeat (bl - 1) @(negedge CLK);
            end else begin
                repeat (bl) @(negedge CLK);
            end
        end
        SER_IN = 1'b1;
        repeat (bl) @(negedge CLK);
    endtask

    // kind: 0 none, 1 one-byte, 2 two-byte; post_at < 0 posts before the frames
    task automatic run_xact(input logic [5:0] ps, input bit pe, input bit pt,
                            input int kind, input int post_at, input int nfr,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input bit bp0, input bit bs0,
                            input bit bp1, input bit bs1);
        int bl;
        bit pend, two, got0;
        logic [7:0] mb0;
        logic [7:0] b;
        bit bp, bs;
        PRESCALE = ps;
        PAR_EN = pe;
        PAR_TYP = pt;
        bl = bitlen(ps);
        pend = (kind > 0);
        two = (kind == 2);
        got0 = 1'b0;
        mb0 = 8'h00;
        if (kind > 0 && post_at < 0) begin
            post(two);
            chk("busy_set", BUSY, 1);
        end
        for (int i = 0; i < nfr; i++) begin
            b = (i == 0) ? b0 : b1;
            bp = pe && ((i == 0) ? bp0 : bp1);
            bs = (i == 0) ? bs0 : bs1;
            send_frame(b, pe, (^b) ^ pt ^ bp, !bs, bl,
                       (i == 0 && kind > 0) ? post_at : -1, two);
            if (bp) e_par++;
            if (bs) e_stp++;
            if (bp || bs) begin
                pend = 1'b0;
            end else if (!pend) begin
                e_unx++;
            end else if (two && !got0) begin
                mb0 = b;
                got0 = 1'b1;
            end else begin
                e_rsp = two ? {b, mb0} : {8'h00, b};
                e_vld++;
                pend = 1'b0;
            end
        end
        repeat (2 * bl) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b0;
        SER_IN = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        EXP_VLD = 1'b0;
        EXP_TWO = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst.busy", BUSY, 0);
        chk("rst.data", RSP_DATA, 16'h0000);
        chk("rst.pulses", {RSP_VLD, PAR_ERR, STP_ERR, UNEXP, TIMEOUT}, 0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        chk_all("idle");

        run_xact(6'd8, 0, 0, 2, -1, 2, 8'h34, 8'h12, 0, 0, 0, 0);
        chk_all("alu8");
        chk("alu8.rsp", last_rsp, 16'h1234);

        run_xact(6'd16, 1, 0, 1, -1, 1, 8'hA5, 8'h00, 0, 0, 0, 0);
        chk_all("rf16");
        chk("rf16.rsp", RSP_DATA, 16'h00A5);

        run_xact(6'd16, 1, 0, 1, -1, 1, 8'hA5, 8'h00, 1, 0, 0, 0);
        chk_all("parerr");

        run_xact(6'd32, 0, 0, 1, -1, 1, 8'h5A, 8'h00, 0, 1, 0, 0);
        chk_all("stperr");
        chk("stperr.hold", RSP_DATA, 16'h00A5);

        PRESCALE = 6'd8;
        SER_IN = 1'b0;
        repeat (2) @(negedge CLK);
        SER_IN = 1'b1;
        repeat (24) @(negedge CLK);
        chk_all("glitch");

        run_xact(6'd8, 0, 0, 0, -1, 1, 8'h3C, 8'h00, 0, 0, 0, 0);
        chk_all("unexp");

        run_xact(6'd16, 0, 1, 2, 3, 2, 8'hCD, 8'hAB, 0, 0, 0, 0);
        chk_all("midpost");
        chk("midpost.rsp", RSP_DATA, 16'hABCD);

`ifdef RSP_TIMEOUT_EN
        PRESCALE = 6'd8;
        PAR_EN = 1'b0;
        post(1'b1);
        send_frame(8'h11, 0, 0, 1, 8, -1, 1'b1);
        repeat (150) @(negedge CLK);
        e_to++;
        chk_all("tmo");
        chk("tmo.when", to_cyc - frame_cyc, 4 + 9 * 8 + 3 + TO_CYC);
`endif

        // Reset in the middle of data bit 4 of 0xFF
        PRESCALE = 6'd8;
        PAR_EN = 1'b0;
        post(1'b0);
        SER_IN = 1'b0;
        repeat (8) @(negedge CLK);
        SER_IN = 1'b1;
        repeat (36) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("mrst.busy", BUSY, 0);
        chk("mrst.data", RSP_DATA, 16'h0000);
        chk("mrst.pulses", {RSP_VLD, PAR_ERR, STP_ERR, UNEXP, TIMEOUT}, 0);
        RST = 1'b1;
        e_rsp = 16'h0000;
        repeat (40) @(negedge CLK);
        chk_all("mrst.idle");
        run_xact(6'd8, 0, 0, 1, -1, 1, 8'h0F, 8'h00, 0, 0, 0, 0);
        chk_all("mrst.after");
        chk("mrst.rsp", RSP_DATA, 16'h000F);

        for (int it = 0; it < 24; it++) begin
            logic [5:0] pl [6];
            logic [5:0] ps;
            int kind, pa, nfr;
            bit pe;
            pl = '{6'd8, 6'd16, 6'd32, 6'd0, 6'd12, 6'd63};
            ps = pl[$urandom_range(0, 5)];
            pe = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 2);
            nfr = (kind == 2) ? 2 : 1;
            pa = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, 8);
            run_xact(ps, pe, 1'($urandom_range(0, 1)), kind, pa, nfr,
                     8'($urandom), 8'($urandom),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            chk_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
